mem_burst_arbiter: RTL

- Two-channel burst arbiter between the frame-processing masters and the single memory-controller burst port.
- Channel 0 is the video write-in path. Channel 1 is the image rotation/shift/scale engine, whose single-beat read/write bursts it consumes directly.
- Serves one burst at a time, round-robin between channels, and routes data, valid, request and finish strobes back to the owning channel.
- Includes a watchdog that flags hung bursts.

---
 rtl/mem_burst_arbiter_if.sv | 60 ++++++
 rtl/mem_burst_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_burst_arbiter_if
//   One burst-port bundle: request/length/address/write-data travelling from
//   the requester towards memory, and beat/finish strobes plus read data
//   travelling back.
//   The same bundle is used for each frame-processing channel and for the
//   memory-controller port.
//
//   modport master : the side that issues bursts (channel master, or the
//                    arbiter towards the controller)
//   modport slave  : the side that serves bursts (the arbiter towards a
//                    channel, or the memory controller)
//
//   Signals
//     rd_burst_req / wr_burst_req         request, held until finish
//     rd_burst_len / wr_burst_len         burst length in beats (10 bits)
//     rd_burst_addr / wr_burst_addr       burst start address
//     wr_burst_data                       write beat data
//     rd_burst_data                       read beat data
//     rd_burst_data_valid                 read beat valid
//     wr_burst_data_req                   write beat request
//     rd_burst_finish / wr_burst_finish   completion strobes
// ---------------------------------------------------------------------------
interface mem_burst_arbiter_if #(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 32
) ();
  logic                 rd_burst_req;
  logic                 wr_burst_req;
  logic [9:0]           rd_burst_len;
  logic [9:0]           wr_burst_len;
  logic [ADDR_BITS-1:0] rd_burst_addr;
  logic [ADDR_BITS-1:0] wr_burst_addr;
  logic [DATA_BITS-1:0] wr_burst_data;
  logic [DATA_BITS-1:0] rd_burst_data;
  logic                 rd_burst_data_valid;
  logic                 wr_burst_data_req;
  logic                 rd_burst_finish;
  logic                 wr_burst_finish;

  modport master (
    output rd_burst_req, wr_burst_req,
    output rd_burst_len, wr_burst_len,
    output rd_burst_addr, wr_burst_addr,
    output wr_burst_data,
    input  rd_burst_data,
    input  rd_burst_data_valid, wr_burst_data_req,
    input  rd_burst_finish, wr_burst_finish
  );

  modport slave (
    input  rd_burst_req, wr_burst_req,
    input  rd_burst_len, wr_burst_len,
    input  rd_burst_addr, wr_burst_addr,
    input  wr_burst_data,
    output rd_burst_data,
    output rd_burst_data_valid, wr_burst_data_req,
    output rd_burst_finish, wr_burst_finish
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// ---------------------------------------------------------------------------
// mem_burst_arbiter
//   Shares one memory-controller burst port between two channels
//   (ch0 = video write-in, ch1 = rotate/shift/scale engine). One burst is in
//   flight at a time; when both channels wait, ownership alternates.
//   Controller strobes are steered to the owning channel only. A watchdog
//   abandons a burst that has not finished within TIMEOUT cycles and raises
//   a sticky error.
//
//   Ports
//     mem_clk   clock, everything on its rising edge
//     rst       synchronous active-high reset
//     ch0, ch1  channel burst ports (arbiter serves them: slave modport)
//     mem       controller burst port (arbiter drives it: master modport)
//     grant_ch  channel that owns, or last owned, the controller port
//     error     sticky watchdog flag, cleared only by rst
// ---------------------------------------------------------------------------
module mem_burst_arbiter #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 32,
  parameter int TIMEOUT       = 4096
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  mem_burst_arbiter_if.slave   ch0,
  mem_burst_arbiter_if.slave   ch1,
  mem_burst_arbiter_if.master  mem,
  output logic                 grant_ch,
  output logic                 error
);

  localparam int WD_BITS = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, TURN} state_t;

  state_t               state_reg, state_next;
  logic                 grant_reg, grant_next;
  logic                 error_reg, error_next;
  logic [WD_BITS-1:0]   wd_reg, wd_next;
  logic                 rd_req_reg, rd_req_next;
  logic                 wr_req_reg, wr_req_next;
  logic [9:0]           rd_len_reg, rd_len_next;
  logic [9:0]           wr_len_reg, wr_len_next;
  logic [ADDR_BITS-1:0] rd_addr_reg, rd_addr_next;
  logic [ADDR_BITS-1:0] wr_addr_reg, wr_addr_next;

  // -------------------------------------------------------------------------
  // Arbitration: when both channels wait, the one that did not own the port
  // last wins; a read beats a write inside the winning channel.
  // -------------------------------------------------------------------------
  logic                 pend0, pend1, any_pend;
  logic                 win_ch, win_rd;
  logic [9:0]           win_rd_len, win_wr_len;
  logic [ADDR_BITS-1:0] win_rd_addr, win_wr_addr;
  logic                 wd_expired;

  assign pend0       = ch0.rd_burst_req | ch0.wr_burst_req;
  assign pend1       = ch1.rd_burst_req | ch1.wr_burst_req;
  assign any_pend    = pend0 | pend1;
  assign win_ch      = (pend0 & pend1) ? ~grant_reg : pend1;
  assign win_rd      = win_ch ? ch1.rd_burst_req  : ch0.rd_burst_req;
  assign win_rd_len  = win_ch ? ch1.rd_burst_len  : ch0.rd_burst_len;
  assign win_wr_len  = win_ch ? ch1.wr_burst_len  : ch0.wr_burst_len;
  assign win_rd_addr = win_ch ? ch1.rd_burst_addr : ch0.rd_burst_addr;
  assign win_wr_addr = win_ch ? ch1.wr_burst_addr : ch0.wr_burst_addr;

  // wd_reg is 0 in the first busy cycle, so hitting TIMEOUT-1 here means the
  // request has been outstanding for TIMEOUT cycles at the next edge.
  assign wd_expired  = (wd_reg == WD_BITS'(TIMEOUT - 1));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b1;  // makes ch0 the first winner after reset
      error_reg   <= 1'b0;
      wd_reg      <= '0;
      rd_req_reg  <= 1'b0;
      wr_req_reg  <= 1'b0;
      rd_len_reg  <= '0;
      wr_len_reg  <= '0;
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      error_reg   <= error_next;
      wd_reg      <= wd_next;
      rd_req_reg  <= rd_req_next;
      wr_req_reg  <= wr_req_next;
      rd_len_reg  <= rd_len_next;
      wr_len_reg  <= wr_len_next;
      rd_addr_reg <= rd_addr_next;
      wr_addr_reg <= wr_addr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    error_next   = error_reg;
    wd_next      = wd_reg;
    rd_req_next  = rd_req_reg;
    wr_req_next  = wr_req_reg;
    rd_len_next  = rd_len_reg;
    wr_len_next  = wr_len_reg;
    rd_addr_next = rd_addr_reg;
    wr_addr_next = wr_addr_reg;

    case (state_reg)
      IDLE: begin
        wd_next = '0;
        if (any_pend) begin
          grant_next = win_ch;
          if (win_rd) begin
            rd_req_next  = 1'b1;
            rd_len_next  = win_rd_len;
            rd_addr_next = win_rd_addr;
            state_next   = RD_BUSY;
          end else begin
            wr_req_next  = 1'b1;
            wr_len_next  = win_wr_len;
            wr_addr_next = win_wr_addr;
            state_next   = WR_BUSY;
          end
        end
      end

      RD_BUSY: begin
        // A write finish here belongs to nobody and is ignored.
        if (mem.rd_burst_finish) begin
          rd_req_next = 1'b0;
          state_next  = TURN;
        end else if (wd_expired) begin
          rd_req_next = 1'b0;
          error_next  = 1'b1;
          state_next  = TURN;
        end else begin
          wd_next = wd_reg + WD_BITS'(1);
        end
      end

      WR_BUSY: begin
        if (mem.wr_burst_finish) begin
          wr_req_next = 1'b0;
          state_next  = TURN;
        end else if (wd_expired) begin
          wr_req_next = 1'b0;
          error_next  = 1'b1;
          state_next  = TURN;
        end else begin
          wd_next = wd_reg + WD_BITS'(1);
        end
      end

      TURN: begin
        // Dead cycle so the finished master can drop its request before
        // arbitration looks again.
        wd_next    = '0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Controller-side outputs
  // -------------------------------------------------------------------------
  assign mem.rd_burst_req  = rd_req_reg;
  assign mem.wr_burst_req  = wr_req_reg;
  assign mem.rd_burst_len  = rd_len_reg;
  assign mem.wr_burst_len  = wr_len_reg;
  assign mem.rd_burst_addr = rd_addr_reg;
  assign mem.wr_burst_addr = wr_addr_reg;
  assign mem.wr_burst_data = grant_reg ? ch1.wr_burst_data : ch0.wr_burst_data;

  // -------------------------------------------------------------------------
  // Channel-side routing. Strobes pass only while a burst of the matching
  // type is open, so stray strobes outside a burst (e.g. after a reset
  // mid-burst, or after a watchdog abort) never reach a channel.
  // -------------------------------------------------------------------------
  logic rd_open, wr_open;

  assign rd_open = (state_reg == RD_BUSY);
  assign wr_open = (state_reg == WR_BUSY);

  assign ch0.rd_burst_data_valid = rd_open & ~grant_reg & mem.rd_burst_data_valid;
  assign ch0.rd_burst_finish     = rd_open & ~grant_reg & mem.rd_burst_finish;
  assign ch0.wr_burst_data_req   = wr_open & ~grant_reg & mem.wr_burst_data_req;
  assign ch0.wr_burst_finish     = wr_open & ~grant_reg & mem.wr_burst_finish;

  assign ch1.rd_burst_data_valid = rd_open &  grant_reg & mem.rd_burst_data_valid;
  assign ch1.rd_burst_finish     = rd_open &  grant_reg & mem.rd_burst_finish;
  assign ch1.wr_burst_data_req   = wr_open &  grant_reg & mem.wr_burst_data_req;
  assign ch1.wr_burst_finish     = wr_open &  grant_reg & mem.wr_burst_finish;

  // Read data is broadcast; the valid strobe tells each channel if it is his.
  assign ch0.rd_burst_data = mem.rd_burst_data;
  assign ch1.rd_burst_data = mem.rd_burst_data;

  assign grant_ch = grant_reg;
  assign error    = error_reg;

endmodule
